// File: rtl/resp_frame_builder.sv
// Response-frame generator: SOF, STATUS, CMD, [LEN], ADDR echo, DATA, CRC-8 into the UART TX FIFO.
// Optional LEN byte on successful reads is enabled by defining RESP_FRAME_LEN_FIELD_EN.
module resp_frame_builder #(
    parameter int unsigned MAX_DATA_BYTES = 64,
    parameter int unsigned ADDR_BYTES     = 4,
    parameter logic [7:0]  SOF_BYTE       = 8'h5A,
    parameter logic [7:0]  CRC_INIT       = 8'h00,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter logic [7:0]  ERR_LEN_STATUS = 8'h04
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_status,
    input  logic [7:0]              req_cmd,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    input  logic [7:0]              req_len,
    input  logic [7:0]              data_byte,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [7:0]              tx_fifo_data,
    output logic                    tx_fifo_wr_en,
    input  logic                    tx_fifo_full,
    output logic                    builder_busy,
    output logic                    response_complete,
    output logic                    len_err,
    output logic [3:0]              fsm_state
);

    // All handshakes (req, data) transfer on a clock edge where valid && ready;
    // the source must hold its payload stable until that edge.

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SOF    = 4'd1;
    localparam logic [3:0] S_STATUS = 4'd2;
    localparam logic [3:0] S_CMD    = 4'd3;
`ifdef RESP_FRAME_LEN_FIELD_EN
    localparam logic [3:0] S_LEN    = 4'd4;
`endif
    localparam logic [3:0] S_ADDR   = 4'd5;
    localparam logic [3:0] S_DATA   = 4'd6;
    localparam logic [3:0] S_CRC    = 4'd7;
    localparam logic [3:0] S_GAP    = 4'd8;

    localparam int unsigned AIW = $clog2(ADDR_BYTES + 1);
    localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);
    localparam logic [AIW-1:0] ADDR_LAST = AIW'(ADDR_BYTES - 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [7:0]     MAX_LEN   = 8'(MAX_DATA_BYTES);

    logic [3:0]              state;
    logic [7:0]              status_q;
    logic [7:0]              cmd_q;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic [7:0]              len_q;
    logic [7:0]              crc_q;
    logic [AIW-1:0]          addr_idx;
    logic [7:0]              data_idx;
    logic [GW-1:0]           gap_cnt;

    logic [7:0] out_byte;
    logic [7:0] addr_byte;
    logic       byte_state;
    logic       crc_en;
    logic       data_fire;
    logic       req_illegal;
    logic       read_ok;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int k = 0; k < 8; k++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign req_illegal = req_cmd[7] && (req_len > MAX_LEN);
    assign read_ok     = cmd_q[7] && (status_q == 8'h00);

    always_comb begin
        addr_byte = 8'h00;
        for (int i = 0; i < int'(ADDR_BYTES); i++) begin
            if (addr_idx == i[AIW-1:0]) begin
                addr_byte = addr_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        out_byte   = 8'h00;
        byte_state = 1'b0;
        case (state)
            S_SOF:    begin out_byte = SOF_BYTE;  byte_state = 1'b1; end
            S_STATUS: begin out_byte = status_q;  byte_state = 1'b1; end
            S_CMD:    begin out_byte = cmd_q;     byte_state = 1'b1; end
`ifdef RESP_FRAME_LEN_FIELD_EN
            S_LEN:    begin out_byte = len_q;     byte_state = 1'b1; end
`endif
            S_ADDR:   begin out_byte = addr_byte; byte_state = 1'b1; end
            S_DATA:   begin out_byte = data_byte; byte_state = 1'b1; end
            S_CRC:    begin out_byte = crc_q;     byte_state = 1'b1; end
            default:  begin out_byte = 8'h00;     byte_state = 1'b0; end
        endcase
    end

    // DATA bytes pass straight through, so a data handshake and a FIFO write are the same event.
    assign data_ready        = (state == S_DATA) && !tx_fifo_full;
    assign data_fire         = data_ready && data_valid;
    assign tx_fifo_wr_en     = byte_state && !tx_fifo_full && ((state != S_DATA) || data_valid);
    assign tx_fifo_data      = byte_state ? out_byte : 8'h00;
    assign crc_en            = tx_fifo_wr_en && (state != S_SOF) && (state != S_CRC);
    assign req_ready         = (state == S_IDLE);
    assign builder_busy      = (state != S_IDLE);
    assign response_complete = (state == S_GAP) && (gap_cnt == '0);
    assign fsm_state         = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            status_q <= 8'h00;
            cmd_q    <= 8'h00;
            addr_q   <= '0;
            len_q    <= 8'h00;
            crc_q    <= CRC_INIT;
            addr_idx <= '0;
            data_idx <= 8'h00;
            gap_cnt  <= '0;
            len_err  <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (crc_en) begin
                crc_q <= crc8_next(crc_q, out_byte);
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        status_q <= req_illegal ? ERR_LEN_STATUS : req_status;
                        cmd_q    <= req_cmd;
                        addr_q   <= req_addr;
                        len_q    <= req_len;
                        crc_q    <= CRC_INIT;
                        addr_idx <= '0;
                        data_idx <= 8'h00;
                        gap_cnt  <= '0;
                        len_err  <= req_illegal;
                        state    <= S_SOF;
                    end
                end
                S_SOF: begin
                    if (tx_fifo_wr_en) state <= S_STATUS;
                end
                S_STATUS: begin
                    if (tx_fifo_wr_en) state <= S_CMD;
                end
                S_CMD: begin
                    if (tx_fifo_wr_en) begin
`ifdef RESP_FRAME_LEN_FIELD_EN
                        state <= read_ok ? S_LEN : S_CRC;
`else
                        state <= read_ok ? S_ADDR : S_CRC;
`endif
                    end
                end
`ifdef RESP_FRAME_LEN_FIELD_EN
                S_LEN: begin
                    if (tx_fifo_wr_en) state <= S_ADDR;
                end
`endif
                S_ADDR: begin
                    if (tx_fifo_wr_en) begin
                        if (addr_idx == ADDR_LAST) begin
                            state <= (len_q != 8'h00) ? S_DATA : S_CRC;
                        end else begin
                            addr_idx <= addr_idx + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (data_fire) begin
                        data_idx <= data_idx + 8'd1;
                        if (data_idx + 8'd1 == len_q) state <= S_CRC;
                    end
                end
                S_CRC: begin
                    if (tx_fifo_wr_en) state <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_frame_builder.sv
// Bench for resp_frame_builder: frame-level reference model feeding byte/length/len_err scoreboards.
// Honours RESP_FRAME_LEN_FIELD_EN when the same define is given to the build.
module tb_resp_frame_builder;
  localparam int unsigned MAX_DATA_BYTES = 64;
  localparam int unsigned ADDR_BYTES     = 4;
  localparam int unsigned GAP_CYCLES     = 2;
  localparam logic [7:0]  SOF_BYTE       = 8'h5A;
  localparam logic [7:0]  CRC_INIT       = 8'h00;
  localparam logic [7:0]  ERR_LEN_STATUS = 8'h04;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic [7:0]              req_status = '0;
  logic [7:0]              req_cmd = '0;
  logic [8*ADDR_BYTES-1:0] req_addr = '0;
  logic [7:0]              req_len = '0;
  logic [7:0]              data_byte;
  logic                    data_valid;
  logic                    data_ready;
  logic [7:0]              tx_fifo_data;
  logic                    tx_fifo_wr_en;
  logic                    tx_fifo_full;
  logic                    builder_busy;
  logic                    response_complete;
  logic                    len_err;
  logic [3:0]              fsm_state;

  resp_frame_builder #(
    .MAX_DATA_BYTES(MAX_DATA_BYTES), .ADDR_BYTES(ADDR_BYTES), .SOF_BYTE(SOF_BYTE),
    .CRC_INIT(CRC_INIT), .GAP_CYCLES(GAP_CYCLES), .ERR_LEN_STATUS(ERR_LEN_STATUS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_status(req_status), .req_cmd(req_cmd), .req_addr(req_addr), .req_len(req_len),
    .data_byte(data_byte), .data_valid(data_valid), .data_ready(data_ready),
    .tx_fifo_data(tx_fifo_data), .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_full(tx_fifo_full),
    .builder_busy(builder_busy), .response_complete(response_complete), .len_err(len_err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int         exp_len_q[$];
  bit         exp_lerr_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] pl_src[$];
  int  bytes_in_frame = 0;
  bit  hs_pending = 1'b0;
  bit  prev_wr = 1'b0;
  bit  src_live = 1'b0;
  int  full_mode = 0;
  int  valid_pct = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  // reference model: CRC as bit-serial long division of the whole message by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [7:0] msg[$]);
    logic [7:0] r;
    logic fb;
    r = CRC_INIT;
    foreach (msg[m]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[m][b];
        r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return r;
  endfunction

  task automatic model_frame(input logic [7:0] st, input logic [7:0] cmd,
                             input logic [8*ADDR_BYTES-1:0] addr, input logic [7:0] len);
    logic [7:0] body[$];
    logic [7:0] p;
    bit illegal;
    bit ok;
    illegal = cmd[7] && (int'(len) > int'(MAX_DATA_BYTES));
    if (illegal) st = ERR_LEN_STATUS;
    ok = cmd[7] && (st == 8'h00);
    body.push_back(st);
    body.push_back(cmd);
    if (ok) begin
`ifdef RESP_FRAME_LEN_FIELD_EN
      body.push_back(len);
`endif
      for (int i = 0; i < int'(ADDR_BYTES); i++) body.push_back(addr[8*i +: 8]);
      for (int i = 0; i < int'(len); i++) begin
        p = (pl_src.size() > 0) ? pl_src.pop_front() : 8'($urandom);
        body.push_back(p);
        pay_q.push_back(p);
      end
    end
    exp_q.push_back(SOF_BYTE);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(crc_ref(body));
    exp_len_q.push_back(body.size() + 2);
    exp_lerr_q.push_back(illegal);
  endtask

  // driver tasks
  task automatic send_req(input logic [7:0] st, input logic [7:0] cmd,
                          input logic [8*ADDR_BYTES-1:0] addr, input logic [7:0] len);
    int n;
    model_frame(st, cmd, addr, len);
    req_status = st;
    req_cmd = cmd;
    req_addr = addr;
    req_len = len;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) flag("req_accept_timeout", 32'(n));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exp_len_q.delete();
    exp_lerr_q.delete();
    pay_q.delete();
    pl_src.delete();
    bytes_in_frame = 0;
    hs_pending = 1'b0;
    prev_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_len_q.size() != 0 || builder_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      flag("idle_timeout", 32'(exp_len_q.size()));
      flush_sb();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {23'd0, req_ready, data_ready, tx_fifo_wr_en, builder_busy,
                 response_complete, len_err, 2'b00} | {24'd0, tx_fifo_data},
          {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
  endtask

  // FIFO back-pressure
  initial begin
    tx_fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (full_mode)
        0: tx_fifo_full = 1'b0;
        1: tx_fifo_full = ~tx_fifo_full;
        default: tx_fifo_full = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // payload source: real bytes from pay_q, otherwise junk that must never be taken
  initial begin
    data_valid = 1'b0;
    data_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && data_valid && data_ready) begin
        if (src_live && pay_q.size() > 0) begin
          checks++;
          void'(pay_q.pop_front());
        end else begin
          flag("junk_byte_consumed", {24'd0, data_byte});
        end
      end
      @(posedge clk);
      #1;
      if (pay_q.size() > 0 && $urandom_range(1, 100) <= valid_pct) begin
        data_valid = 1'b1;
        data_byte = pay_q[0];
        src_live = 1'b1;
      end else if (pay_q.size() == 0 && $urandom_range(0, 1) == 1) begin
        data_valid = 1'b1;
        data_byte = 8'($urandom);
        src_live = 1'b0;
      end else begin
        data_valid = 1'b0;
        src_live = 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_fifo_wr_en) begin
        check("wr_while_full", {31'd0, tx_fifo_full}, 32'd0);
        if (exp_q.size() == 0) flag("unexpected_byte", {24'd0, tx_fifo_data});
        else check("tx_byte", {24'd0, tx_fifo_data}, {24'd0, exp_q.pop_front()});
        bytes_in_frame++;
      end
      if (response_complete) begin
        check("complete_after_crc", {31'd0, prev_wr}, 32'd1);
        if (exp_len_q.size() == 0) flag("unexpected_complete", 32'(bytes_in_frame));
        else check("frame_len", 32'(bytes_in_frame), 32'(exp_len_q.pop_front()));
        bytes_in_frame = 0;
      end
      if (hs_pending) begin
        if (exp_lerr_q.size() == 0) flag("unexpected_handshake", {31'd0, len_err});
        else check("len_err", {31'd0, len_err}, {31'd0, exp_lerr_q.pop_front()});
      end else if (len_err) begin
        flag("len_err_spurious", 32'd1);
      end
      hs_pending = req_valid && req_ready;
      prev_wr = tx_fifo_wr_en;
    end
  end

  initial begin
    int n;
    logic [7:0] st;
    logic [7:0] cmd;
    logic [7:0] len;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk);
    #1;

    // write response, FIFO never full: 5A 00 20 E0, busy for 4+GAP cycles
    full_mode = 0;
    send_req(8'h00, 8'h20, 32'h0, 8'd0);
    n = 0;
    @(negedge clk);
    while (builder_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("write_busy_cycles", 32'(n), 32'(4 + GAP_CYCLES));
    wait_idle(200);

    // read success with fixed payload
    pl_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_req(8'h00, 8'hA0, 32'h1234_5678, 8'd4);
    wait_idle(200);

    // read error status, junk presented on the data port
    send_req(8'h03, 8'hA0, 32'h1234_5678, 8'd4);
    wait_idle(200);

    // illegal length, then boundary lengths MAX and 0
    send_req(8'h00, 8'hA0, 32'hCAFE_F00D, 8'(MAX_DATA_BYTES + 1));
    wait_idle(200);
    send_req(8'h00, 8'hA5, 32'h0BAD_BEEF, 8'(MAX_DATA_BYTES));
    wait_idle(500);
    send_req(8'h00, 8'h80, 32'h0102_0304, 8'd0);
    wait_idle(200);

    // stalls: FIFO full every other cycle and gappy payload
    full_mode = 1;
    valid_pct = 40;
    pl_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_req(8'h00, 8'hA0, 32'h1234_5678, 8'd4);
    send_req(8'h00, 8'h20, 32'h0, 8'd0);
    send_req(8'h00, 8'h81, 32'($urandom), 8'd12);
    wait_idle(1000);

    // reset in the middle of DATA
    full_mode = 0;
    valid_pct = 100;
    send_req(8'h00, 8'h81, 32'($urandom), 8'd30);
    n = 0;
    @(negedge clk);
    while (!(data_valid && data_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) flag("data_phase_timeout", 32'(n));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    flush_sb();
    data_valid = 1'b0;
    src_live = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid_data");
    @(posedge clk);
    #1;
    send_req(8'h00, 8'hB3, 32'h89AB_CDEF, 8'd3);
    wait_idle(300);

    // randomized back-to-back frames
    for (int f = 0; f < 60; f++) begin
      full_mode = $urandom_range(0, 2);
      valid_pct = $urandom_range(30, 100);
      st = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      cmd = 8'($urandom);
      case ($urandom_range(0, 5))
        0: len = 8'($urandom_range(MAX_DATA_BYTES + 1, 255));
        1: len = 8'(MAX_DATA_BYTES);
        2: len = 8'd0;
        default: len = 8'($urandom_range(1, 20));
      endcase
      send_req(st, cmd, 32'($urandom), len);
    end
    wait_idle(20000);

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("payload_drained", 32'(pay_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=finish", checks);
    $fatal(1, "global timeout");
  end
endmodule
